// File: rtl/conveyor_batch_ctrl.sv
// Conveyor batch controller: counts IR object edges while the belt runs,
// stops the motor when the batch target is reached, and flags a jam when
// no object is seen for JAM_TIMEOUT_MS while running.
module conveyor_batch_ctrl #(
  parameter int CLOCK_FREQ     = 50_000_000,
  parameter int JAM_TIMEOUT_MS = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       abort_i,
  input  logic       obj_i,
  input  logic [7:0] batch_target_i,
  input  logic [7:0] pwm_duty_i,
  output logic       motor_en_o,
  output logic [1:0] motor_sel_o,
  output logic [7:0] pwm_duty_o,
  output logic [7:0] count_o,
  output logic       batch_done_o,
  output logic       jam_o,
  output logic [2:0] state_o
);

  localparam int JAM_CYCLES = (CLOCK_FREQ / 1000) * JAM_TIMEOUT_MS;
  localparam int TW         = (JAM_CYCLES > 1) ? $clog2(JAM_CYCLES + 1) : 1;
  localparam logic [TW-1:0] JAM_LAST = TW'(JAM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3,
    S_JAM   = 3'd4
  } state_t;

  state_t        state, nxt_state;
  logic [7:0]    count, nxt_count;
  logic [7:0]    target, nxt_target;
  logic [TW-1:0] timer, nxt_timer;
  logic          obj_q;
  logic          obj_edge;
  logic [7:0]    cnt_inc;
  logic          tgt_ok;

  // Rising edge of the object sensor against its registered copy
  assign obj_edge = obj_i & ~obj_q;
  // count < target holds in RUN, so the increment cannot overflow
  assign cnt_inc  = count + 8'd1;
  assign tgt_ok   = (batch_target_i != 8'd0);

  assign state_o  = state;
  assign count_o  = count;

  // Next-state, count, target and jam-timer decisions
  always_comb begin
    nxt_state  = state;
    nxt_count  = count;
    nxt_target = target;
    nxt_timer  = timer;
    if (abort_i) begin
      // count is kept for display; flags drop with the state
      nxt_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i && tgt_ok) begin
            nxt_state  = S_RUN;
            nxt_target = batch_target_i;
            nxt_count  = 8'd0;
            nxt_timer  = '0;
          end
        end
        S_RUN: begin
          // Timer saturates at the jam limit so a pause taken on the last
          // cycle resumes straight into the timeout instead of wrapping.
          if (obj_edge) begin
            nxt_count = cnt_inc;
            nxt_timer = '0;
          end else if (timer != JAM_LAST) begin
            nxt_timer = timer + TW'(1);
          end
          if (obj_edge && (cnt_inc == target)) nxt_state = S_DONE;
          else if (pause_i)                    nxt_state = S_PAUSE;
          else if (!obj_edge && timer == JAM_LAST) nxt_state = S_JAM;
        end
        S_PAUSE: begin
          if (pause_i) nxt_state = S_RUN;
        end
        S_JAM: begin
          if (start_i) begin
            nxt_state = S_RUN;
            nxt_timer = '0;
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  // State and registered outputs, all decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= 8'd0;
      target       <= 8'd0;
      timer        <= '0;
      obj_q        <= 1'b0;
      motor_en_o   <= 1'b0;
      motor_sel_o  <= 2'b00;
      pwm_duty_o   <= 8'd0;
      batch_done_o <= 1'b0;
      jam_o        <= 1'b0;
    end else begin
      state        <= nxt_state;
      count        <= nxt_count;
      target       <= nxt_target;
      timer        <= nxt_timer;
      obj_q        <= obj_i;
      motor_en_o   <= (nxt_state == S_RUN);
      motor_sel_o  <= (nxt_state == S_RUN) ? 2'b01 : 2'b00;
      pwm_duty_o   <= (nxt_state == S_RUN) ? pwm_duty_i : 8'd0;
      batch_done_o <= (nxt_state == S_DONE);
      jam_o        <= (nxt_state == S_JAM);
    end
  end

endmodule
